// File: rtl/mdio_frame_engine_pkg.sv
// ============================================================================
// mdio_frame_engine_pkg : Clause-22 MDIO frame constants and frame builder
// Rev 1.0
// ============================================================================
`default_nettype none

package mdio_frame_engine_pkg;

  localparam int unsigned MDIO_PRE_LEN   = 32;
  localparam int unsigned MDIO_FRAME_LEN = 64;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;

  localparam logic [5:0] MDIO_TA1_IDX  = 6'd46;
  localparam logic [5:0] MDIO_TA2_IDX  = 6'd47;
  localparam logic [5:0] MDIO_DATA_IDX = 6'd48;
  localparam logic [5:0] MDIO_LAST_IDX = 6'd63;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_EDGE = 2'd1,
    ST_SHIFT     = 2'd2
  } state_e;

  typedef logic [MDIO_FRAME_LEN-1:0] frame_t;

  // Read frames carry ones in TA/DATA; those bits are never driven anyway.
  function automatic frame_t build_frame(input logic        rh_wl,
                                         input logic [4:0]  phyad,
                                         input logic [4:0]  regad,
                                         input logic [15:0] wr_data);
    frame_t f;
    f = {{MDIO_PRE_LEN{1'b1}}, MDIO_ST, (rh_wl ? MDIO_OP_RD : MDIO_OP_WR),
         phyad, regad, (rh_wl ? 2'b11 : 2'b10), (rh_wl ? 16'hFFFF : wr_data)};
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdio_frame_engine_if.sv
// ============================================================================
// mdio_frame_engine_if : command/response bundle between poll FSM and engine
// Rev 1.0
// ============================================================================
`default_nettype none

interface mdio_frame_engine_if;
  logic        op_exec;
  logic        op_rh_wl;
  logic [4:0]  op_addr;
  logic [15:0] op_wr_data;
  logic        op_done;
  logic [15:0] op_rd_data;
  logic        op_rd_ack;

  modport master (
    output op_exec, op_rh_wl, op_addr, op_wr_data,
    input  op_done, op_rd_data, op_rd_ack
  );

  modport slave (
    input  op_exec, op_rh_wl, op_addr, op_wr_data,
    output op_done, op_rd_data, op_rd_ack
  );
endinterface

`default_nettype wire

// File: rtl/mdio_clk_div.sv
// ============================================================================
// mdio_clk_div : free-running MDC generator with registered edge strobes
// Rev 1.0
// ============================================================================
`default_nettype none

module mdio_clk_div #(
  parameter logic [7:0] CLK_DIV = 8'd25
) (
  input  logic clk,
  input  logic rst_n,
  output logic mdc_o,
  output logic mdc_rise_o,
  output logic mdc_fall_o
);

  logic [7:0] cnt_q;
  logic       mdc_q;
  logic       rise_q;
  logic       fall_q;

  // Strobes are high in the first clk of the new MDC level, so anything
  // launched from them changes one clk after the pin edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 8'd0;
      mdc_q  <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (cnt_q == CLK_DIV - 8'd1) begin
        cnt_q  <= 8'd0;
        mdc_q  <= ~mdc_q;
        rise_q <= ~mdc_q;
        fall_q <= mdc_q;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign mdc_o      = mdc_q;
  assign mdc_rise_o = rise_q;
  assign mdc_fall_o = fall_q;

endmodule

`default_nettype wire

// File: rtl/mdio_frame_engine.sv
// ============================================================================
// mdio_frame_engine : Clause-22 MDIO master, one 64-bit frame per op_exec
// Rev 1.0
// ============================================================================
`default_nettype none

module mdio_frame_engine
  import mdio_frame_engine_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'b00001,
  parameter logic [7:0] CLK_DIV  = 8'd25
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mdio_frame_engine_if.slave   op,
  output logic                 eth_mdc,
  output logic                 eth_mdio_o,
  output logic                 eth_mdio_oe,
  input  logic                 eth_mdio_i
);

  logic        mdc_rise;
  logic        mdc_fall;

  state_e      state_q;
  frame_t      tx_q;
  logic        rd_q;
  logic [5:0]  bit_cnt_q;
  logic [15:0] rx_q;
  logic        ack_q;
  logic        mdio_o_q;
  logic        mdio_oe_q;
  logic        done_q;
  logic [15:0] rd_data_q;
  logic        rd_ack_q;
  logic        sync1_q;
  logic        sync2_q;

  mdio_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .mdc_o      (eth_mdc),
    .mdc_rise_o (mdc_rise),
    .mdc_fall_o (mdc_fall)
  );

  // Idle level of the synchroniser matches the bus pull-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= eth_mdio_i;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tx_q      <= '1;
      rd_q      <= 1'b0;
      bit_cnt_q <= 6'd0;
      rx_q      <= 16'd0;
      ack_q     <= 1'b1;
      mdio_o_q  <= 1'b1;
      mdio_oe_q <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= 16'd0;
      rd_ack_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (op.op_exec) begin
            rd_q    <= op.op_rh_wl;
            tx_q    <= build_frame(op.op_rh_wl, PHY_ADDR, op.op_addr, op.op_wr_data);
            state_q <= ST_WAIT_EDGE;
          end
        end
        ST_WAIT_EDGE: begin
          if (mdc_fall) begin
            mdio_o_q  <= tx_q[MDIO_FRAME_LEN-1];
            mdio_oe_q <= 1'b1;
            tx_q      <= {tx_q[MDIO_FRAME_LEN-2:0], 1'b1};
            bit_cnt_q <= 6'd0;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (mdc_rise && rd_q) begin
            if (bit_cnt_q == MDIO_TA2_IDX)   ack_q <= sync2_q;
            if (bit_cnt_q >= MDIO_DATA_IDX)  rx_q  <= {rx_q[14:0], sync2_q};
          end
          if (mdc_fall) begin
            if (bit_cnt_q == MDIO_LAST_IDX) begin
              mdio_o_q  <= 1'b1;
              mdio_oe_q <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= ST_IDLE;
              if (rd_q) begin
                rd_data_q <= rx_q;
                rd_ack_q  <= ack_q;
              end else begin
                rd_ack_q  <= 1'b0;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 6'd1;
              mdio_o_q  <= tx_q[MDIO_FRAME_LEN-1];
              tx_q      <= {tx_q[MDIO_FRAME_LEN-2:0], 1'b1};
              // Reads hand the bus to the PHY from the first turnaround bit.
              mdio_oe_q <= !(rd_q && ((bit_cnt_q + 6'd1) >= MDIO_TA1_IDX));
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign eth_mdio_o    = mdio_o_q;
  assign eth_mdio_oe   = mdio_oe_q;
  assign op.op_done    = done_q;
  assign op.op_rd_data = rd_data_q;
  assign op.op_rd_ack  = rd_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_mdio_frame_engine.sv
// ============================================================================
// tb_mdio_frame_engine : self-checking bench with pin-level frame monitor and PHY model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mdio_frame_engine;

  localparam int DIV    = 25;
  localparam int LAT_LO = 128 * DIV + 1;
  localparam int LAT_HI = 128 * DIV + 2 * DIV + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic eth_mdc, eth_mdio_o, eth_mdio_oe, eth_mdio_i;
  logic phy_pin = 1'b1;

  int n_checks = 0;
  int n_fail = 0;

  mdio_frame_engine_if u_if();

  mdio_frame_engine #(.PHY_ADDR(5'b00001), .CLK_DIV(8'd25)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (u_if),
    .eth_mdc     (eth_mdc),
    .eth_mdio_o  (eth_mdio_o),
    .eth_mdio_oe (eth_mdio_oe),
    .eth_mdio_i  (eth_mdio_i)
  );

  assign eth_mdio_i = phy_pin;
  always #5 clk = ~clk;

  // Pin monitor: frame bits as the PHY would see them on MDC rise, plus a PHY model
  bit          in_frame = 0;
  int          nbits = 0;
  int          frames_cnt = 0;
  int          done_cnt = 0;
  int          bad_trans = 0;
  int          since_fall = 99;
  logic        prev_mdc = 1'b1, prev_o = 1'b1, prev_oe = 1'b0;
  logic [63:0] fbits = '0, foe = '0, last_bits = '0, last_oe = '0;
  bit          phy_present = 0;
  logic [15:0] phy_data = 16'h0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0; nbits = 0; since_fall = 99; phy_pin = 1'b1;
      prev_mdc = eth_mdc; prev_o = eth_mdio_o; prev_oe = eth_mdio_oe;
    end else begin
      if (u_if.op_done === 1'b1) done_cnt++;
      if (prev_mdc && !eth_mdc) since_fall = 0;
      else if (since_fall < 99) since_fall++;
      if ((eth_mdio_o !== prev_o || eth_mdio_oe !== prev_oe) && since_fall != 1) bad_trans++;
      if (!prev_mdc && eth_mdc) begin
        if (!in_frame && eth_mdio_oe === 1'b1) begin in_frame = 1; nbits = 0; end
        if (in_frame) begin
          fbits[63-nbits] = eth_mdio_o;
          foe[63-nbits]   = eth_mdio_oe;
          nbits++;
          if (nbits == 64) begin
            in_frame = 0; frames_cnt++; last_bits = fbits; last_oe = foe;
          end
        end
      end
      if (prev_mdc && !eth_mdc) begin
        phy_pin = 1'b1;
        if (in_frame && phy_present && fbits[29:28] == 2'b10 && nbits >= 47 && nbits <= 63)
          phy_pin = (nbits == 47) ? 1'b0 : phy_data[63-nbits];
      end
      prev_mdc = eth_mdc; prev_o = eth_mdio_o; prev_oe = eth_mdio_oe;
    end
  end

  // Reference: rd_data/rd_ack as the control FSM should see them
  logic [15:0] mdl_rd_data = 16'h0;
  logic        mdl_ack = 1'b1;

  function automatic logic [63:0] exp_frame(input bit rd, input logic [4:0] a, input logic [15:0] d);
    logic [1:0] opc;
    opc = rd ? 2'b10 : 2'b01;
    return {32'hFFFF_FFFF, 2'b01, opc, 5'b00001, a, 2'b10, d};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic issue(input bit rd, input logic [4:0] a, input logic [15:0] d);
    u_if.op_rh_wl = rd; u_if.op_addr = a; u_if.op_wr_data = d; u_if.op_exec = 1'b1;
    @(negedge clk); #1;
    u_if.op_exec = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit to, output int cyc);
    to = 1; cyc = 0;
    while (cyc < budget) begin
      @(negedge clk); #1; cyc++;
      if (u_if.op_done === 1'b1) begin to = 0; return; end
    end
  endtask

  task automatic wait_bits(input int n, input int budget, output bit to);
    to = 1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (in_frame && nbits == n) begin to = 0; return; end
    end
  endtask

  task automatic test_reset;
    idle(3);
    n_checks++; if (eth_mdc !== 1'b1) begin n_fail++; $display("FAIL reset_mdc got %b want 1", eth_mdc); end
    n_checks++; if (eth_mdio_o !== 1'b1) begin n_fail++; $display("FAIL reset_mdio_o got %b want 1", eth_mdio_o); end
    n_checks++; if (eth_mdio_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe got %b want 0", eth_mdio_oe); end
    n_checks++; if (u_if.op_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", u_if.op_done); end
    n_checks++; if (u_if.op_rd_data !== 16'h0) begin n_fail++; $display("FAIL reset_rd_data got %h want 0000", u_if.op_rd_data); end
    n_checks++; if (u_if.op_rd_ack !== 1'b1) begin n_fail++; $display("FAIL reset_rd_ack got %b want 1", u_if.op_rd_ack); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_mdc_period;
    int hi, lo;
    hi = 0; lo = 0;
    for (int i = 0; i < 100 && eth_mdc !== 1'b0; i++) idle(1);
    for (int i = 0; i < 100 && eth_mdc !== 1'b1; i++) idle(1);
    while (eth_mdc === 1'b1 && hi < 200) begin hi++; idle(1); end
    while (eth_mdc === 1'b0 && lo < 200) begin lo++; idle(1); end
    n_checks++; if (hi !== DIV) begin n_fail++; $display("FAIL mdc_high got %0d want %0d", hi, DIV); end
    n_checks++; if (hi + lo !== 2 * DIV) begin n_fail++; $display("FAIL mdc_period got %0d want %0d", hi + lo, 2 * DIV); end
  endtask

  task automatic test_write;
    logic [63:0] want;
    int f0, d0, b0, cyc;
    bit to;
    want = {32'hFFFF_FFFF, 4'b0101, 5'b00001, 5'b00000, 2'b10, 16'b1001000101000000};
    f0 = frames_cnt; d0 = done_cnt; b0 = bad_trans;
    issue(1'b0, 5'd0, 16'h9140);
    wait_done(4000, to, cyc);
    n_checks++; if (to) begin n_fail++; $display("FAIL write_done_timeout got none want op_done"); end
    n_checks++; if (cyc < LAT_LO || cyc > LAT_HI) begin n_fail++; $display("FAIL write_latency got %0d want %0d..%0d", cyc, LAT_LO, LAT_HI); end
    n_checks++; if (last_bits !== want) begin n_fail++; $display("FAIL write_frame got %h want %h", last_bits, want); end
    n_checks++; if (last_oe !== {64{1'b1}}) begin n_fail++; $display("FAIL write_oe got %h want all ones", last_oe); end
    n_checks++; if (frames_cnt !== f0 + 1) begin n_fail++; $display("FAIL write_frames got %0d want %0d", frames_cnt - f0, 1); end
    idle(200);
    n_checks++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL write_done_count got %0d want 1", done_cnt - d0); end
    n_checks++; if (eth_mdio_oe !== 1'b0 || eth_mdio_o !== 1'b1) begin n_fail++; $display("FAIL write_release got oe=%b o=%b want oe=0 o=1", eth_mdio_oe, eth_mdio_o); end
    mdl_ack = 1'b0;
    n_checks++; if (u_if.op_rd_ack !== mdl_ack) begin n_fail++; $display("FAIL write_ack got %b want %b", u_if.op_rd_ack, mdl_ack); end
    n_checks++; if (u_if.op_rd_data !== mdl_rd_data) begin n_fail++; $display("FAIL write_rd_data got %h want %h", u_if.op_rd_data, mdl_rd_data); end
    n_checks++; if (bad_trans !== b0) begin n_fail++; $display("FAIL write_mdio_timing got %0d want 0 stray transitions", bad_trans - b0); end
  endtask

  // One complete read with the given PHY behaviour, checked against the model
  task automatic test_read(input string tag, input logic [4:0] a, input bit present, input logic [15:0] d);
    logic [63:0] want;
    int cyc, b0;
    bit to;
    b0 = bad_trans;
    phy_present = present; phy_data = d;
    issue(1'b1, a, $urandom);
    wait_done(4000, to, cyc);
    mdl_rd_data = present ? d : 16'hFFFF;
    mdl_ack     = present ? 1'b0 : 1'b1;
    want = exp_frame(1'b1, a, 16'h0);
    n_checks++; if (to) begin n_fail++; $display("FAIL %s_done_timeout got none want op_done", tag); end
    n_checks++; if (u_if.op_rd_data !== mdl_rd_data) begin n_fail++; $display("FAIL %s_rd_data got %h want %h", tag, u_if.op_rd_data, mdl_rd_data); end
    n_checks++; if (u_if.op_rd_ack !== mdl_ack) begin n_fail++; $display("FAIL %s_rd_ack got %b want %b", tag, u_if.op_rd_ack, mdl_ack); end
    n_checks++; if (last_bits[63:18] !== want[63:18]) begin n_fail++; $display("FAIL %s_header got %h want %h", tag, last_bits[63:18], want[63:18]); end
    n_checks++; if (last_oe !== {{46{1'b1}}, 18'h0}) begin n_fail++; $display("FAIL %s_oe got %h want %h", tag, last_oe, {{46{1'b1}}, 18'h0}); end
    n_checks++; if (bad_trans !== b0) begin n_fail++; $display("FAIL %s_mdio_timing got %0d want 0 stray transitions", tag, bad_trans - b0); end
    phy_present = 0;
    idle(5);
  endtask

  task automatic test_back_to_back;
    logic [15:0] d1, d2;
    logic [4:0]  a1, a2;
    int f0, d0, cyc;
    bit to;
    d1 = 16'($urandom); d2 = 16'($urandom); a1 = 5'($urandom); a2 = 5'($urandom);
    f0 = frames_cnt; d0 = done_cnt;
    issue(1'b0, a1, d1);
    wait_bits(10, 4000, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL b2b_bit10_timeout got none want bit 10"); end
    issue(1'b1, ~a1, ~d1);
    wait_done(4000, to, cyc);
    n_checks++; if (to) begin n_fail++; $display("FAIL b2b_first_done_timeout got none want op_done"); end
    n_checks++; if (frames_cnt !== f0 + 1 || last_bits !== exp_frame(1'b0, a1, d1)) begin
      n_fail++; $display("FAIL b2b_first_frame got %h (%0d frames) want %h (1 frame)", last_bits, frames_cnt - f0, exp_frame(1'b0, a1, d1)); end
    issue(1'b0, a2, d2);
    wait_done(4000, to, cyc);
    n_checks++; if (to) begin n_fail++; $display("FAIL b2b_second_done_timeout got none want op_done"); end
    n_checks++; if (last_bits !== exp_frame(1'b0, a2, d2)) begin n_fail++; $display("FAIL b2b_second_frame got %h want %h", last_bits, exp_frame(1'b0, a2, d2)); end
    idle(100);
    n_checks++; if (done_cnt !== d0 + 2 || frames_cnt !== f0 + 2) begin
      n_fail++; $display("FAIL b2b_counts got %0d done %0d frames want 2 and 2", done_cnt - d0, frames_cnt - f0); end
    mdl_ack = 1'b0;
  endtask

  task automatic test_reset_mid;
    int d0;
    bit to;
    phy_present = 1; phy_data = 16'h1234;
    issue(1'b1, 5'd3, 16'h0);
    wait_bits(40, 4000, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL rstmid_bit40_timeout got none want bit 40"); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (eth_mdc !== 1'b1 || eth_mdio_o !== 1'b1 || eth_mdio_oe !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_pins got mdc=%b o=%b oe=%b want 1 1 0", eth_mdc, eth_mdio_o, eth_mdio_oe); end
    n_checks++; if (u_if.op_done !== 1'b0 || u_if.op_rd_data !== 16'h0 || u_if.op_rd_ack !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_op got done=%b data=%h ack=%b want 0 0000 1", u_if.op_done, u_if.op_rd_data, u_if.op_rd_ack); end
    mdl_rd_data = 16'h0; mdl_ack = 1'b1;
    idle(3);
    rst_n = 1'b1;
    d0 = done_cnt;
    idle(400);
    n_checks++; if (done_cnt !== d0) begin n_fail++; $display("FAIL rstmid_no_done got %0d pulses want 0", done_cnt - d0); end
    test_read("rstmid_read", 5'($urandom), 1'b1, 16'($urandom));
  endtask

  task automatic test_random;
    bit rd, pres, to;
    logic [4:0]  a;
    logic [15:0] d;
    int cyc;
    for (int i = 0; i < 4; i++) begin
      rd = 1'($urandom_range(0, 1)); a = 5'($urandom); d = 16'($urandom); pres = 1'($urandom_range(0, 1));
      if (rd) begin
        test_read("rand_read", a, pres, d);
      end else begin
        issue(1'b0, a, d);
        wait_done(4000, to, cyc);
        mdl_ack = 1'b0;
        n_checks++; if (to || last_bits !== exp_frame(1'b0, a, d)) begin
          n_fail++; $display("FAIL rand_write_frame got %h timeout=%0b want %h", last_bits, to, exp_frame(1'b0, a, d)); end
        n_checks++; if (u_if.op_rd_ack !== mdl_ack || u_if.op_rd_data !== mdl_rd_data) begin
          n_fail++; $display("FAIL rand_write_status got ack=%b data=%h want ack=%b data=%h", u_if.op_rd_ack, u_if.op_rd_data, mdl_ack, mdl_rd_data); end
        idle(5);
      end
    end
  endtask

  initial begin
    u_if.op_exec = 1'b0; u_if.op_rh_wl = 1'b0; u_if.op_addr = 5'd0; u_if.op_wr_data = 16'h0;
    test_reset();
    test_mdc_period();
    test_write();
    test_read("read_ack", 5'd1, 1'b1, 16'h796D);
    test_read("read_noack", 5'd17, 1'b0, 16'h0);
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900us;
    $display("FAIL watchdog got no end of test want finish before 900us");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
